// File: rtl/dm_write_buffer_responder_pkg.sv
// Shared widths and the write-buffer entry type
// for the data-memory responder.
package dm_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int MEM_SIZE   = 16;
  localparam int DEPTH_LOG2 = 8;
  localparam int WB_DEPTH   = 4;

  typedef struct packed {
    logic                 valid;
    logic [MEM_SIZE-1:0]  addr;
    logic [DATA_SIZE-1:0] data;
  } wb_entry_t;

  function automatic logic addr_hit(
    input wb_entry_t           e,
    input logic [MEM_SIZE-1:0] a
  );
    return e.valid && (e.addr == a);
  endfunction

endpackage

// File: rtl/dm_write_buffer_responder_if.sv
// CPU store/load port plus debug req/ack port
// of the data-memory responder.
interface dm_write_buffer_responder_if #(
  parameter int data_size = dm_pkg::DATA_SIZE,
  parameter int mem_size  = dm_pkg::MEM_SIZE,
  parameter int wb_depth  = dm_pkg::WB_DEPTH,
  localparam int CW       = $clog2(wb_depth) + 1
);

  logic [mem_size-1:0]  DM_Address;
  logic                 DM_enable;
  logic [data_size-1:0] DM_Write_Data;
  logic [data_size-1:0] DM_Read_Data;
  logic                 DM_stall;

  logic                 dbg_req;
  logic                 dbg_we;
  logic [mem_size-1:0]  dbg_addr;
  logic [data_size-1:0] dbg_wdata;
  logic                 dbg_ack;
  logic [data_size-1:0] dbg_rdata;

  logic [CW-1:0]        wb_count;

  modport master (
    output DM_Address, DM_enable, DM_Write_Data,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  DM_Read_Data, DM_stall,
    input  dbg_ack, dbg_rdata, wb_count
  );

  modport slave (
    input  DM_Address, DM_enable, DM_Write_Data,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output DM_Read_Data, DM_stall,
    output dbg_ack, dbg_rdata, wb_count
  );

endinterface

// File: rtl/dm_write_buffer_responder_wb_fifo.sv
// Circular posted-store buffer with per-entry
// address compare for CPU loads and debug hazards.
module wb_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int IW    = DEPTH_LOG2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [MEM_SIZE-1:0]  push_addr_i,
  input  logic [DATA_SIZE-1:0] push_data_i,
  input  logic                 pop_i,
  input  logic [MEM_SIZE-1:0]  ld_addr_i,
  input  logic [MEM_SIZE-1:0]  dbg_addr_i,
  output logic                 ld_hit_o,
  output logic [DATA_SIZE-1:0] ld_data_o,
  output logic                 dbg_hit_o,
  output logic [IW-1:0]        head_idx_o,
  output logic [DATA_SIZE-1:0] head_data_o,
  output logic [CW-1:0]        count_o
);

  wb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ord [DEPTH];

  assign head_d = head_q + PW'(pop_i);
  assign tail_d = tail_q + PW'(push_i);
  assign cnt_d  = cnt_q + CW'(push_i) - CW'(pop_i);

  // Slot indices ordered oldest (head) to newest.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord[i] = head_q + PW'(i);
    end
  end

  // Later (newer) matches override older ones.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    dbg_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_hit(ent_q[ord[i]], ld_addr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = ent_q[ord[i]].data;
      end
      if (addr_hit(ent_q[i], dbg_addr_i)) begin
        dbg_hit_o = 1'b1;
      end
    end
  end

  // Push at tail, pop at head; both may happen together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        ent_q[tail_q] <= '{valid: 1'b1,
                           addr:  push_addr_i,
                           data:  push_data_i};
      end
      if (pop_i) begin
        ent_q[head_q].valid <= 1'b0;
      end
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_idx_o  = ent_q[head_q].addr[IW-1:0];
  assign head_data_o = ent_q[head_q].data;
  assign count_o     = cnt_q;

endmodule

// File: rtl/dm_write_buffer_responder.sv
// Data-memory responder: posted write buffer,
// word array and debug port sharing one array port.
module dm_write_buffer_responder
  import dm_pkg::*;
#(
  parameter int depth_log2 = DEPTH_LOG2,
  parameter int wb_depth   = WB_DEPTH,
  localparam int DEPTH     = 1 << depth_log2,
  localparam int CW        = $clog2(wb_depth) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  dm_write_buffer_responder_if.slave    bus
);

  logic                  full;
  logic                  push;
  logic                  drain;
  logic                  hazard;
  logic                  grant;
  logic                  ld_hit;
  logic                  dbg_hit;
  logic [DATA_SIZE-1:0]  ld_data;
  logic [depth_log2-1:0] head_idx;
  logic [DATA_SIZE-1:0]  head_data;
  logic [CW-1:0]         count;
  logic [depth_log2-1:0] cpu_idx;
  logic [depth_log2-1:0] dbg_idx;

  logic [DATA_SIZE-1:0]  mem_q [DEPTH];
  logic                  we_d;
  logic [depth_log2-1:0] waddr_d;
  logic [DATA_SIZE-1:0]  wdata_d;
  logic                  ack_q, ack_d;
  logic [DATA_SIZE-1:0]  rdata_q, rdata_d;

  assign cpu_idx = bus.DM_Address[depth_log2-1:0];
  assign dbg_idx = bus.dbg_addr[depth_log2-1:0];

  wb_fifo #(
    .DEPTH (wb_depth),
    .IW    (depth_log2)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (bus.DM_Address),
    .push_data_i (bus.DM_Write_Data),
    .pop_i       (drain),
    .ld_addr_i   (bus.DM_Address),
    .dbg_addr_i  (bus.dbg_addr),
    .ld_hit_o    (ld_hit),
    .ld_data_o   (ld_data),
    .dbg_hit_o   (dbg_hit),
    .head_idx_o  (head_idx),
    .head_data_o (head_data),
    .count_o     (count)
  );

  // Debug wins the array port only when hazard-free
  // and not full; otherwise the oldest entry drains.
  assign full   = (count == CW'(wb_depth));
  assign push   = bus.DM_enable & ~full;
  assign hazard = bus.dbg_req & dbg_hit;
  assign grant  = bus.dbg_req & ~ack_q & ~full
                & ~hazard;
  assign drain  = (count != '0) & ~grant;

  // Select the single array write for this cycle.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = head_idx;
    wdata_d = head_data;
    unique case (1'b1)
      grant && bus.dbg_we: begin
        we_d    = 1'b1;
        waddr_d = dbg_idx;
        wdata_d = bus.dbg_wdata;
      end
      drain: begin
        we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Debug completion pulse and held read data.
  always_comb begin
    ack_d   = grant;
    rdata_d = rdata_q;
    if (grant && !bus.dbg_we) begin
      rdata_d = mem_q[dbg_idx];
    end
  end

  // Word array, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_d) begin
      mem_q[waddr_d] <= wdata_d;
    end
  end

  // Debug ack/rdata registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.DM_stall     = bus.DM_enable & full;
  assign bus.DM_Read_Data = ld_hit ? ld_data
                                   : mem_q[cpu_idx];
  assign bus.dbg_ack      = ack_q;
  assign bus.dbg_rdata    = rdata_q;
  assign bus.wb_count     = count;

endmodule

// File: tb/tb_dm_write_buffer_responder.sv
// Directed bench for the data-memory responder:
// CPU vector table plus multi-cycle debug sequences.
module tb_dm_write_buffer_responder;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  dm_write_buffer_responder_if bus ();

  dm_write_buffer_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [15];

  logic [2:0] t2_cnt   [10] = '{0,1,1,2,2,3,3,4,3,4};
  logic       t2_ack   [10] = '{0,1,0,1,0,1,0,1,0,1};
  logic       t2_stall [10] = '{0,0,0,0,0,0,0,1,0,0};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.DM_enable     = 1'b0;
    bus.DM_Address    = '0;
    bus.DM_Write_Data = '0;
    bus.dbg_req       = 1'b0;
    bus.dbg_we        = 1'b0;
    bus.dbg_addr      = '0;
    bus.dbg_wdata     = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tbl[0]  = '{0, 16'h0005, 32'h0, 32'h0, 0, 3'd0};
    tbl[1]  = '{1, 16'h0005, 32'hDEADBEEF, 32'h0, 0, 3'd0};
    tbl[2]  = '{0, 16'h0005, 32'h0, 32'hDEADBEEF, 0, 3'd1};
    tbl[3]  = '{0, 16'h0005, 32'h0, 32'hDEADBEEF, 0, 3'd0};
    tbl[4]  = '{1, 16'h0030, 32'h1, 32'h0, 0, 3'd0};
    tbl[5]  = '{1, 16'h0030, 32'h2, 32'h1, 0, 3'd1};
    tbl[6]  = '{0, 16'h0030, 32'h0, 32'h2, 0, 3'd1};
    tbl[7]  = '{0, 16'h0030, 32'h0, 32'h2, 0, 3'd0};
    tbl[8]  = '{1, 16'h0130, 32'h3, 32'h2, 0, 3'd0};
    tbl[9]  = '{0, 16'h0030, 32'h0, 32'h2, 0, 3'd1};
    tbl[10] = '{0, 16'h0030, 32'h0, 32'h3, 0, 3'd0};
    tbl[11] = '{0, 16'h0105, 32'h0, 32'hDEADBEEF, 0, 3'd0};
    tbl[12] = '{1, 16'h0010, 32'h1010, 32'h0, 0, 3'd0};
    tbl[13] = '{0, 16'h0010, 32'h0, 32'h1010, 0, 3'd1};
    tbl[14] = '{0, 16'h0010, 32'h0, 32'h1010, 0, 3'd0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_cnt", 32'(bus.wb_count), 32'd0);
    chk("rst_ack", 32'(bus.dbg_ack), 32'd0);
    chk("rst_rdata", bus.dbg_rdata, 32'd0);
    chk("rst_stall", 32'(bus.DM_stall), 32'd0);
    chk("rst_load", bus.DM_Read_Data, 32'd0);

    // CPU-only store/load vectors
    for (int i = 0; i < 15; i++) begin
      bus.DM_enable     = tbl[i].en;
      bus.DM_Address    = tbl[i].addr;
      bus.DM_Write_Data = tbl[i].wd;
      #2;
      chk($sformatf("v%0d_rd", i),
          bus.DM_Read_Data, tbl[i].rd);
      chk($sformatf("v%0d_stall", i),
          32'(bus.DM_stall), 32'(tbl[i].stall));
      chk($sformatf("v%0d_cnt", i),
          32'(bus.wb_count), 32'(tbl[i].cnt));
      tick();
    end

    // Held debug read while CPU streams stores to full
    for (int i = 0; i < 10; i++) begin
      bus.DM_enable  = (i < 9);
      bus.DM_Address = (i < 8) ? 16'(16'h20 + i)
                               : 16'h0027;
      bus.DM_Write_Data = 32'h100
                        + 32'(bus.DM_Address);
      bus.dbg_req  = (i < 9);
      bus.dbg_we   = 1'b0;
      bus.dbg_addr = 16'h0010;
      #2;
      chk($sformatf("t2_cnt%0d", i),
          32'(bus.wb_count), 32'(t2_cnt[i]));
      chk($sformatf("t2_ack%0d", i),
          32'(bus.dbg_ack), 32'(t2_ack[i]));
      chk($sformatf("t2_stall%0d", i),
          32'(bus.DM_stall), 32'(t2_stall[i]));
      if (t2_ack[i]) begin
        chk($sformatf("t2_rdata%0d", i),
            bus.dbg_rdata, 32'h1010);
      end
      tick();
    end
    idle();
    for (int k = 0; k < 8 && bus.wb_count != 0; k++) begin
      tick();
    end
    chk("t2_drained", 32'(bus.wb_count), 32'd0);
    bus.DM_Address = 16'h0027;
    #1 chk("t2_ld27", bus.DM_Read_Data, 32'h127);
    bus.DM_Address = 16'h0020;
    #1 chk("t2_ld20", bus.DM_Read_Data, 32'h120);
    bus.DM_Address = 16'h0023;
    #1 chk("t2_ld23", bus.DM_Read_Data, 32'h123);
    tick();

    // Debug read blocked by a buffered store to 0x40
    bus.DM_enable     = 1'b1;
    bus.DM_Address    = 16'h0040;
    bus.DM_Write_Data = 32'hCAFE;
    tick();
    bus.DM_Address    = 16'h0041;
    bus.DM_Write_Data = 32'hBEEF;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 16'h0040;
    #2;
    chk("t4_ack_c1", 32'(bus.dbg_ack), 32'd0);
    chk("t4_cnt_c1", 32'(bus.wb_count), 32'd1);
    tick();
    bus.DM_enable = 1'b0;
    #2;
    chk("t4_ack_c2", 32'(bus.dbg_ack), 32'd0);
    tick();
    chk("t4_ack_c3", 32'(bus.dbg_ack), 32'd1);
    chk("t4_rdata", bus.dbg_rdata, 32'hCAFE);
    bus.dbg_req = 1'b0;
    tick();
    chk("t4_ack_c4", 32'(bus.dbg_ack), 32'd0);
    chk("t4_cnt_c4", 32'(bus.wb_count), 32'd0);

    // Debug write, single ack with req held
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 16'h0050;
    bus.dbg_wdata = 32'h1234;
    #2;
    chk("t5_ack_c0", 32'(bus.dbg_ack), 32'd0);
    tick();
    chk("t5_ack_c1", 32'(bus.dbg_ack), 32'd1);
    chk("t5_rdata_held", bus.dbg_rdata, 32'hCAFE);
    tick();
    idle();
    bus.DM_Address = 16'h0050;
    #1;
    chk("t5_ack_c2", 32'(bus.dbg_ack), 32'd0);
    chk("t5_ld50", bus.DM_Read_Data, 32'h1234);
    tick();
    chk("t5_ack_c3", 32'(bus.dbg_ack), 32'd0);

    // Async reset with 3 buffered entries and debug pending
    for (int i = 0; i < 5; i++) begin
      bus.DM_enable     = 1'b1;
      bus.DM_Address    = 16'(16'h60 + i);
      bus.DM_Write_Data = 32'h600 + 32'(i);
      bus.dbg_req  = 1'b1;
      bus.dbg_we   = 1'b0;
      bus.dbg_addr = 16'h0010;
      tick();
    end
    bus.DM_enable  = 1'b0;
    bus.DM_Address = 16'h0064;
    #1;
    chk("t6_pre_cnt", 32'(bus.wb_count), 32'd3);
    chk("t6_pre_ack", 32'(bus.dbg_ack), 32'd1);
    chk("t6_pre_ld", bus.DM_Read_Data, 32'h604);
    rst = 1'b0;
    #1;
    chk("t6_cnt", 32'(bus.wb_count), 32'd0);
    chk("t6_ack", 32'(bus.dbg_ack), 32'd0);
    chk("t6_rdata", bus.dbg_rdata, 32'd0);
    chk("t6_ld64", bus.DM_Read_Data, 32'd0);
    bus.DM_Address = 16'h0050;
    bus.DM_enable  = 1'b1;
    #1;
    chk("t6_ld50", bus.DM_Read_Data, 32'd0);
    chk("t6_stall", 32'(bus.DM_stall), 32'd0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();
    chk("t6_post_ack", 32'(bus.dbg_ack), 32'd0);
    chk("t6_post_cnt", 32'(bus.wb_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
